hba_mailbox: RTL and testbench

- HBA bus slave (responder) that answers transfers issued by the serial_fpga bus master.
- Provides two byte FIFOs between the host and local FPGA logic:
  - TX FIFO: host writes, local logic drains.
  - RX FIFO: local logic fills, host reads.
- Raises a level interrupt toward the interrupt controller in serial_fpga.
- Sits in one HBA slot.

---
 rtl/hba_mailbox_pkg.sv | 28 ++
 rtl/hba_sync_fifo.sv | 52 +++++
 rtl/hba_mailbox.sv | 144 ++++++++++++++
 tb/tb_hba_mailbox.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hba_mailbox_pkg.sv
// Shared definitions for the HBA mailbox: register map, CTRL/STATUS bit
// positions and the bus-handshake state encoding.
package hba_mailbox_pkg;

    localparam int unsigned REG_CTRL     = 0;
    localparam int unsigned REG_STATUS   = 1;
    localparam int unsigned REG_TX_DATA  = 2;
    localparam int unsigned REG_RX_DATA  = 3;
    localparam int unsigned REG_RX_COUNT = 4;
    localparam int unsigned REG_TX_COUNT = 5;

    localparam int CTRL_RX_IRQ_EN       = 0;
    localparam int CTRL_TX_EMPTY_IRQ_EN = 1;

    localparam int STAT_RX_NOT_EMPTY = 0;
    localparam int STAT_RX_FULL      = 1;
    localparam int STAT_TX_EMPTY     = 2;
    localparam int STAT_TX_FULL      = 3;
    localparam int STAT_RX_OVF       = 4;
    localparam int STAT_TX_OVF       = 5;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_ACK  = 2'd1,
        BUS_HOLD = 2'd2
    } bus_state_t;

endpackage

// File: rtl/hba_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head reads 0 while empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module hba_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/hba_mailbox.sv
// HBA slave exposing a host->local TX FIFO and a local->host RX FIFO,
// with a CSR pair (CTRL/STATUS) and a level interrupt.
module hba_mailbox #(
    parameter int DBUS_WIDTH        = 8,
    parameter int PERIPH_ADDR_WIDTH = 4,
    parameter int REG_ADDR_WIDTH    = 8,
    parameter int PERIPH_ADDR       = 5,
    parameter int FIFO_DEPTH        = 8
) (
    input  logic                                      hba_clk,
    input  logic                                      hba_reset,
    input  logic                                      hba_rnw,
    input  logic                                      hba_select,
    input  logic [PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH-1:0] hba_abus,
    input  logic [DBUS_WIDTH-1:0]                     hba_dbus,
    output logic [DBUS_WIDTH-1:0]                     hba_dbus_slave,
    output logic                                      hba_xferack_slave,
    output logic                                      slave_interrupt,
    input  logic                                      rx_wr_en,
    input  logic [DBUS_WIDTH-1:0]                     rx_wr_data,
    input  logic                                      tx_rd_en,
    output logic [DBUS_WIDTH-1:0]                     tx_rd_data,
    output logic                                      tx_valid
);
    import hba_mailbox_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    bus_state_t                   state, state_next;
    logic                         hit, accept;
    logic [PERIPH_ADDR_WIDTH-1:0] slot;
    int unsigned                  reg_idx;
    logic [DBUS_WIDTH-1:0]        rd_mux, rd_q;
    logic [1:0]                   ctrl;
    logic                         rx_ovf, tx_ovf, irq_q;
    logic                         ctrl_wr, stat_wr, tx_push, rx_pop;
    logic                         rx_ovf_set, tx_ovf_set;
    logic [DBUS_WIDTH-1:0]        rx_head, tx_head;
    logic                         rx_empty, rx_full, tx_empty, tx_full;
    logic [CW-1:0]                rx_count, tx_count;
    logic                         unused_dbus;

    assign slot    = hba_abus[PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH-1 -: PERIPH_ADDR_WIDTH];
    assign reg_idx = 32'(hba_abus[REG_ADDR_WIDTH-1:0]);
    assign hit     = hba_select & (slot == PERIPH_ADDR_WIDTH'(PERIPH_ADDR));

    // Side effects fire only on the IDLE->ACK edge, so a held select acts once.
    always_comb begin
        state_next        = state;
        accept            = 1'b0;
        hba_xferack_slave = 1'b0;
        case (state)
            BUS_IDLE: if (hit) begin
                accept     = 1'b1;
                state_next = BUS_ACK;
            end
            BUS_ACK: begin
                hba_xferack_slave = 1'b1;
                state_next        = BUS_HOLD;
            end
            BUS_HOLD: if (!hba_select) state_next = BUS_IDLE;
            default:  state_next = BUS_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (reg_idx)
            REG_CTRL:     rd_mux[1:0] = ctrl;
            REG_STATUS: begin
                rd_mux[STAT_RX_NOT_EMPTY] = ~rx_empty;
                rd_mux[STAT_RX_FULL]      = rx_full;
                rd_mux[STAT_TX_EMPTY]     = tx_empty;
                rd_mux[STAT_TX_FULL]      = tx_full;
                rd_mux[STAT_RX_OVF]       = rx_ovf;
                rd_mux[STAT_TX_OVF]       = tx_ovf;
            end
            REG_RX_DATA:  rd_mux = rx_head;
            REG_RX_COUNT: rd_mux = DBUS_WIDTH'(rx_count);
            REG_TX_COUNT: rd_mux = DBUS_WIDTH'(tx_count);
            default:      rd_mux = '0;
        endcase
    end

    assign ctrl_wr = accept & ~hba_rnw & (reg_idx == REG_CTRL);
    assign stat_wr = accept & ~hba_rnw & (reg_idx == REG_STATUS);
    assign tx_push = accept & ~hba_rnw & (reg_idx == REG_TX_DATA);
    assign rx_pop  = accept &  hba_rnw & (reg_idx == REG_RX_DATA);

    // A full FIFO still absorbs a push when it is popped in the same cycle.
    assign rx_ovf_set = rx_wr_en & rx_full & ~rx_pop;
    assign tx_ovf_set = tx_push & tx_full & ~tx_rd_en;

    always_ff @(posedge hba_clk or negedge hba_reset) begin
        if (!hba_reset) begin
            state  <= BUS_IDLE;
            rd_q   <= '0;
            ctrl   <= '0;
            rx_ovf <= 1'b0;
            tx_ovf <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            state  <= state_next;
            rd_q   <= (accept & hba_rnw) ? rd_mux : '0;
            if (ctrl_wr)
                ctrl <= hba_dbus[1:0];
            rx_ovf <= (rx_ovf & ~(stat_wr & hba_dbus[STAT_RX_OVF])) | rx_ovf_set;
            tx_ovf <= (tx_ovf & ~(stat_wr & hba_dbus[STAT_TX_OVF])) | tx_ovf_set;
            irq_q  <= (ctrl[CTRL_RX_IRQ_EN] & ~rx_empty) |
                      (ctrl[CTRL_TX_EMPTY_IRQ_EN] & tx_empty);
        end
    end

    hba_sync_fifo #(.WIDTH(DBUS_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (hba_clk),
        .rst_n     (hba_reset),
        .push      (rx_wr_en),
        .push_data (rx_wr_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .empty     (rx_empty),
        .full      (rx_full),
        .count     (rx_count)
    );

    hba_sync_fifo #(.WIDTH(DBUS_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (hba_clk),
        .rst_n     (hba_reset),
        .push      (tx_push),
        .push_data (hba_dbus),
        .pop       (tx_rd_en),
        .head      (tx_head),
        .empty     (tx_empty),
        .full      (tx_full),
        .count     (tx_count)
    );

    assign hba_dbus_slave  = rd_q;
    assign slave_interrupt = irq_q;
    assign tx_rd_data      = tx_head;
    assign tx_valid        = ~tx_empty;
    assign unused_dbus     = ^hba_dbus;

endmodule

// File: tb/tb_hba_mailbox.sv
// Self-checking bench for hba_mailbox: directed scenarios plus a randomized
// mix of bus and local traffic checked against a queue-based model.
module tb_hba_mailbox;

    logic        clk = 1'b0;
    logic        hba_reset = 1'b0;
    logic        hba_rnw = 1'b0;
    logic        hba_select = 1'b0;
    logic [11:0] hba_abus = '0;
    logic [7:0]  hba_dbus = '0;
    logic [7:0]  hba_dbus_slave;
    logic        hba_xferack_slave;
    logic        slave_interrupt;
    logic        rx_wr_en = 1'b0;
    logic [7:0]  rx_wr_data = '0;
    logic        tx_rd_en = 1'b0;
    logic [7:0]  tx_rd_data;
    logic        tx_valid;

    int total = 0;
    int bad = 0;

    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [1:0] m_ctrl = '0;
    logic       m_rx_ovf = 1'b0;
    logic       m_tx_ovf = 1'b0;

    always #5 clk = ~clk;

    hba_mailbox dut (
        .hba_clk           (clk),
        .hba_reset         (hba_reset),
        .hba_rnw           (hba_rnw),
        .hba_select        (hba_select),
        .hba_abus          (hba_abus),
        .hba_dbus          (hba_dbus),
        .hba_dbus_slave    (hba_dbus_slave),
        .hba_xferack_slave (hba_xferack_slave),
        .slave_interrupt   (slave_interrupt),
        .rx_wr_en          (rx_wr_en),
        .rx_wr_data        (rx_wr_data),
        .tx_rd_en          (tx_rd_en),
        .tx_rd_data        (tx_rd_data),
        .tx_valid          (tx_valid)
    );

    // ---------------- reference model ----------------
    function automatic void m_reset();
        rxq.delete();
        txq.delete();
        m_ctrl = '0;
        m_rx_ovf = 1'b0;
        m_tx_ovf = 1'b0;
    endfunction

    function automatic logic [7:0] m_status();
        return {2'b00, m_tx_ovf, m_rx_ovf, 1'(txq.size() == 8), 1'(txq.size() == 0),
                1'(rxq.size() == 8), 1'(rxq.size() != 0)};
    endfunction

    function automatic logic [7:0] m_read(input int r);
        case (r)
            0: return {6'b0, m_ctrl};
            1: return m_status();
            3: return (rxq.size() != 0) ? rxq[0] : 8'h00;
            4: return 8'(rxq.size());
            5: return 8'(txq.size());
            default: return 8'h00;
        endcase
    endfunction

    function automatic void m_bus(input logic rnw, input int r, input logic [7:0] wd);
        if (rnw) begin
            if (r == 3 && rxq.size() != 0) rxq.delete(0);
        end else begin
            case (r)
                0: m_ctrl = wd[1:0];
                1: begin
                    if (wd[4]) m_rx_ovf = 1'b0;
                    if (wd[5]) m_tx_ovf = 1'b0;
                end
                2: if (txq.size() < 8) txq.push_back(wd); else m_tx_ovf = 1'b1;
                default: ;
            endcase
        end
    endfunction

    function automatic logic m_irq();
        return (m_ctrl[0] && rxq.size() != 0) || (m_ctrl[1] && txq.size() == 0);
    endfunction

    // ---------------- drivers ----------------
    // hs = ack low before the first edge, high one cycle after select, low after.
    task automatic bus_xfer(input logic rnw, input logic [11:0] addr, input logic [7:0] wd,
                            output logic [7:0] rd, output logic hs);
        logic a0, a1;
        @(negedge clk);
        hba_select = 1'b1; hba_rnw = rnw; hba_abus = addr; hba_dbus = wd;
        a0 = hba_xferack_slave;
        @(negedge clk);
        a1 = hba_xferack_slave;
        rd = hba_dbus_slave;
        hba_select = 1'b0; hba_rnw = 1'b0; hba_dbus = '0;
        @(negedge clk);
        hs = !a0 && a1 && !hba_xferack_slave && (hba_dbus_slave == 8'h00);
    endtask

    task automatic rx_push(input logic [7:0] d);
        @(negedge clk);
        rx_wr_en = 1'b1; rx_wr_data = d;
        @(negedge clk);
        rx_wr_en = 1'b0;
        if (rxq.size() < 8) rxq.push_back(d); else m_rx_ovf = 1'b1;
    endtask

    task automatic tx_pop();
        @(negedge clk);
        tx_rd_en = 1'b1;
        @(negedge clk);
        tx_rd_en = 1'b0;
        if (txq.size() != 0) txq.delete(0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [7:0] rd; logic hs;
        hba_reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (hba_xferack_slave !== 1'b0 || hba_dbus_slave !== 8'h00 || slave_interrupt !== 1'b0 ||
            tx_valid !== 1'b0 || tx_rd_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs: ack=%b dbus=%h irq=%b txv=%b txd=%h want all 0",
                     hba_xferack_slave, hba_dbus_slave, slave_interrupt, tx_valid, tx_rd_data);
        end
        hba_reset = 1'b1;
        m_reset();
        bus_xfer(1'b1, 12'h501, 8'h00, rd, hs);
        total++;
        if (hs !== 1'b1 || rd !== 8'h04) begin
            bad++; $display("FAIL reset_status: got %h hs=%b want 04 hs=1", rd, hs);
        end
        total++;
        if (slave_interrupt !== 1'b0) begin
            bad++; $display("FAIL reset_irq: got %b want 0", slave_interrupt);
        end
    endtask

    task automatic test_tx_path();
        logic [7:0] rd; logic hs;
        bus_xfer(1'b0, 12'h502, 8'hA5, rd, hs); m_bus(1'b0, 2, 8'hA5);
        bus_xfer(1'b0, 12'h502, 8'h3C, rd, hs); m_bus(1'b0, 2, 8'h3C);
        bus_xfer(1'b1, 12'h505, 8'h00, rd, hs);
        total++;
        if (hs !== 1'b1 || rd !== 8'h02) begin
            bad++; $display("FAIL tx_count_2: got %h hs=%b want 02", rd, hs);
        end
        total++;
        if (tx_valid !== 1'b1 || tx_rd_data !== 8'hA5) begin
            bad++; $display("FAIL tx_head_0: got v=%b d=%h want v=1 d=a5", tx_valid, tx_rd_data);
        end
        tx_pop();
        total++;
        if (tx_valid !== 1'b1 || tx_rd_data !== 8'h3C) begin
            bad++; $display("FAIL tx_head_1: got v=%b d=%h want v=1 d=3c", tx_valid, tx_rd_data);
        end
        tx_pop();
        total++;
        if (tx_valid !== 1'b0 || tx_rd_data !== 8'h00) begin
            bad++; $display("FAIL tx_drained: got v=%b d=%h want v=0 d=00", tx_valid, tx_rd_data);
        end
        bus_xfer(1'b1, 12'h505, 8'h00, rd, hs);
        total++;
        if (hs !== 1'b1 || rd !== 8'h00) begin
            bad++; $display("FAIL tx_count_0: got %h hs=%b want 00", rd, hs);
        end
    endtask

    task automatic test_rx_overflow();
        logic [7:0] rd, exp; logic hs;
        for (int i = 1; i <= 9; i++) rx_push(8'(i));
        bus_xfer(1'b1, 12'h504, 8'h00, rd, hs);
        total++;
        if (hs !== 1'b1 || rd !== 8'h08) begin
            bad++; $display("FAIL rx_count_full: got %h hs=%b want 08", rd, hs);
        end
        exp = m_status();
        bus_xfer(1'b1, 12'h501, 8'h00, rd, hs);
        total++;
        if (hs !== 1'b1 || rd !== exp || rd[4] !== 1'b1) begin
            bad++; $display("FAIL rx_full_status: got %h hs=%b want %h", rd, hs, exp);
        end
        for (int i = 1; i <= 9; i++) begin
            exp = (i <= 8) ? 8'(i) : 8'h00;
            bus_xfer(1'b1, 12'h503, 8'h00, rd, hs);
            m_bus(1'b1, 3, 8'h00);
            total++;
            if (hs !== 1'b1 || rd !== exp) begin
                bad++; $display("FAIL rx_drain_%0d: got %h hs=%b want %h", i, rd, hs, exp);
            end
        end
        bus_xfer(1'b1, 12'h504, 8'h00, rd, hs);
        total++;
        if (hs !== 1'b1 || rd !== 8'h00) begin
            bad++; $display("FAIL rx_count_empty: got %h hs=%b want 00", rd, hs);
        end
        bus_xfer(1'b0, 12'h501, 8'h10, rd, hs); m_bus(1'b0, 1, 8'h10);
    endtask

    task automatic test_coincident();
        logic [7:0] rd, exp, d; logic hs, a1;
        // Empty RX: bus pop ignored while the local push lands.
        @(negedge clk);
        hba_select = 1'b1; hba_rnw = 1'b1; hba_abus = 12'h503; rx_wr_en = 1'b1; rx_wr_data = 8'h5A;
        @(negedge clk);
        a1 = hba_xferack_slave; rd = hba_dbus_slave; hba_select = 1'b0; rx_wr_en = 1'b0;
        @(negedge clk);
        rxq.push_back(8'h5A);
        total++;
        if (a1 !== 1'b1 || rd !== 8'h00) begin
            bad++; $display("FAIL empty_pop_push: got %h ack=%b want 00 ack=1", rd, a1);
        end
        for (int i = 0; i < 7; i++) rx_push(8'($urandom));
        // Full RX: bus pop and local push together, no overflow.
        d = 8'($urandom);
        exp = rxq[0];
        @(negedge clk);
        hba_select = 1'b1; hba_rnw = 1'b1; hba_abus = 12'h503; rx_wr_en = 1'b1; rx_wr_data = d;
        @(negedge clk);
        a1 = hba_xferack_slave; rd = hba_dbus_slave; hba_select = 1'b0; rx_wr_en = 1'b0;
        @(negedge clk);
        rxq.delete(0); rxq.push_back(d);
        total++;
        if (a1 !== 1'b1 || rd !== exp) begin
            bad++; $display("FAIL full_pop_push: got %h ack=%b want %h", rd, a1, exp);
        end
        for (int r = 1; r <= 4; r += 3) begin
            exp = m_read(r);
            bus_xfer(1'b1, {4'h5, 8'(r)}, 8'h00, rd, hs);
            total++;
            if (hs !== 1'b1 || rd !== exp) begin
                bad++; $display("FAIL full_coinc_reg%0d: got %h hs=%b want %h", r, rd, hs, exp);
            end
        end
        rx_push(8'hEE);
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin bus_xfer(1'b0, 12'h501, 8'h10, rd, hs); m_bus(1'b0, 1, 8'h10); end
            if (k == 1) continue;
            exp = m_read(1);
            bus_xfer(1'b1, 12'h501, 8'h00, rd, hs);
            total++;
            if (hs !== 1'b1 || rd !== exp) begin
                bad++; $display("FAIL rx_ovf_w1c_%0d: got %h hs=%b want %h", k, rd, hs, exp);
            end
        end
        // Full TX: bus push and local pop together, no overflow.
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            bus_xfer(1'b0, 12'h502, d, rd, hs); m_bus(1'b0, 2, d);
        end
        d = 8'($urandom);
        @(negedge clk);
        hba_select = 1'b1; hba_rnw = 1'b0; hba_abus = 12'h502; hba_dbus = d; tx_rd_en = 1'b1;
        @(negedge clk);
        hba_select = 1'b0; tx_rd_en = 1'b0;
        @(negedge clk);
        txq.delete(0); txq.push_back(d);
        exp = m_status();
        bus_xfer(1'b1, 12'h501, 8'h00, rd, hs);
        total++;
        if (hs !== 1'b1 || rd !== exp || rd[5] !== 1'b0) begin
            bad++; $display("FAIL tx_full_coinc: got %h hs=%b want %h", rd, hs, exp);
        end
        for (int i = 0; i < 8; i++) begin
            exp = txq[0];
            total++;
            if (tx_valid !== 1'b1 || tx_rd_data !== exp) begin
                bad++; $display("FAIL tx_drain_%0d: got v=%b d=%h want %h", i, tx_valid, tx_rd_data, exp);
            end
            tx_pop();
        end
        for (int i = 0; i < 8; i++) begin
            exp = m_read(3);
            bus_xfer(1'b1, 12'h503, 8'h00, rd, hs); m_bus(1'b1, 3, 8'h00);
            total++;
            if (hs !== 1'b1 || rd !== exp) begin
                bad++; $display("FAIL rx_drain2_%0d: got %h hs=%b want %h", i, rd, hs, exp);
            end
        end
    endtask

    task automatic test_irq();
        logic [7:0] rd; logic hs;
        bus_xfer(1'b0, 12'h500, 8'h01, rd, hs); m_bus(1'b0, 0, 8'h01);
        total++;
        if (slave_interrupt !== 1'b0) begin
            bad++; $display("FAIL irq_idle: got %b want 0", slave_interrupt);
        end
        rx_push(8'h77);
        @(negedge clk);
        total++;
        if (slave_interrupt !== 1'b1) begin
            bad++; $display("FAIL irq_rx: got %b want 1", slave_interrupt);
        end
        bus_xfer(1'b1, 12'h503, 8'h00, rd, hs); m_bus(1'b1, 3, 8'h00);
        total++;
        if (slave_interrupt !== 1'b0 || rd !== 8'h77) begin
            bad++; $display("FAIL irq_rx_clear: got irq=%b d=%h want irq=0 d=77", slave_interrupt, rd);
        end
        bus_xfer(1'b0, 12'h500, 8'h02, rd, hs); m_bus(1'b0, 0, 8'h02);
        total++;
        if (slave_interrupt !== 1'b1) begin
            bad++; $display("FAIL irq_tx_empty: got %b want 1", slave_interrupt);
        end
        bus_xfer(1'b0, 12'h500, 8'h00, rd, hs); m_bus(1'b0, 0, 8'h00);
    endtask

    task automatic test_held_select();
        logic [7:0] rd, got, first; logic hs; int acks;
        first = 8'($urandom);
        rx_push(first);
        rx_push(8'($urandom));
        acks = 0; got = '0;
        @(negedge clk);
        hba_select = 1'b1; hba_rnw = 1'b1; hba_abus = 12'h503;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (hba_xferack_slave === 1'b1) begin acks++; got = hba_dbus_slave; end
        end
        hba_select = 1'b0;
        @(negedge clk);
        m_bus(1'b1, 3, 8'h00);
        total++;
        if (acks != 1 || got !== first) begin
            bad++; $display("FAIL held_select: acks=%0d d=%h want acks=1 d=%h", acks, got, first);
        end
        bus_xfer(1'b1, 12'h504, 8'h00, rd, hs);
        total++;
        if (hs !== 1'b1 || rd !== 8'h01) begin
            bad++; $display("FAIL held_count: got %h hs=%b want 01", rd, hs);
        end
    endtask

    task automatic test_wrong_slot();
        logic [7:0] rd; logic hs; int seen;
        seen = 0;
        @(negedge clk);
        hba_select = 1'b1; hba_rnw = 1'b1; hba_abus = 12'h403;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (hba_xferack_slave !== 1'b0 || hba_dbus_slave !== 8'h00) seen++;
        end
        hba_select = 1'b0;
        total++;
        if (seen != 0) begin
            bad++; $display("FAIL wrong_slot: active cycles=%0d want 0", seen);
        end
        bus_xfer(1'b1, 12'h504, 8'h00, rd, hs);
        total++;
        if (hs !== 1'b1 || rd !== 8'(rxq.size())) begin
            bad++; $display("FAIL wrong_slot_count: got %h hs=%b want %h", rd, hs, 8'(rxq.size()));
        end
    endtask

    task automatic test_random();
        logic [7:0] rd, exp, d; logic hs, ev; int op, r;
        for (int it = 0; it < 250; it++) begin
            @(negedge clk);
            ev = m_irq();
            total++;
            if (slave_interrupt !== ev) begin
                bad++; $display("FAIL rand_irq_%0d: got %b want %b", it, slave_interrupt, ev);
            end
            op = $urandom_range(0, 7);
            d = 8'($urandom);
            case (op)
                0, 1: rx_push(d);
                2: begin
                    exp = (txq.size() != 0) ? txq[0] : 8'h00;
                    ev = (txq.size() != 0);
                    total++;
                    if (tx_valid !== ev || tx_rd_data !== exp) begin
                        bad++; $display("FAIL rand_txhead_%0d: got v=%b d=%h want v=%b d=%h",
                                        it, tx_valid, tx_rd_data, ev, exp);
                    end
                    tx_pop();
                end
                default: begin
                    case (op)
                        3: r = 2;
                        4: r = 3;
                        6: r = $urandom_range(0, 1);
                        default: r = $urandom_range(0, 7);
                    endcase
                    if (op == 4 || op == 5) begin
                        exp = m_read(r);
                        bus_xfer(1'b1, {4'h5, 8'(r)}, 8'h00, rd, hs);
                        m_bus(1'b1, r, 8'h00);
                    end else begin
                        exp = 8'h00;
                        bus_xfer(1'b0, {4'h5, 8'(r)}, d, rd, hs);
                        m_bus(1'b0, r, d);
                    end
                    total++;
                    if (hs !== 1'b1 || rd !== exp) begin
                        bad++; $display("FAIL rand_bus_%0d_reg%0d: got %h hs=%b want %h", it, r, rd, hs, exp);
                    end
                end
            endcase
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd; logic hs; logic a1;
        rx_push(8'h11);
        bus_xfer(1'b0, 12'h502, 8'h22, rd, hs); m_bus(1'b0, 2, 8'h22);
        @(negedge clk);
        hba_select = 1'b1; hba_rnw = 1'b1; hba_abus = 12'h505;
        @(negedge clk);
        a1 = hba_xferack_slave;
        #1 hba_reset = 1'b0;
        #1;
        total++;
        if (a1 !== 1'b1 || hba_xferack_slave !== 1'b0 || hba_dbus_slave !== 8'h00 || tx_valid !== 1'b0) begin
            bad++; $display("FAIL reset_mid: ack_before=%b ack=%b dbus=%h txv=%b want 1 0 00 0",
                            a1, hba_xferack_slave, hba_dbus_slave, tx_valid);
        end
        hba_select = 1'b0;
        @(negedge clk);
        hba_reset = 1'b1;
        m_reset();
        bus_xfer(1'b1, 12'h504, 8'h00, rd, hs);
        total++;
        if (hs !== 1'b1 || rd !== 8'h00) begin
            bad++; $display("FAIL reset_mid_rx_count: got %h hs=%b want 00", rd, hs);
        end
    endtask

    initial begin
        test_reset();
        test_tx_path();
        test_rx_overflow();
        test_coincident();
        test_irq();
        test_held_select();
        test_wrong_slot();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
